// File: rtl/osr_if.sv
// osr_if: TX FIFO handshake between a FIFO (slave) and the output shift register (master).
//  fifo_empty  FIFO -> OSR  head word not valid
//  fifo_data   FIFO -> OSR  head word
//  fifo_pop    OSR -> FIFO  one-cycle pop strobe
interface osr_if;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_pop;
  modport master (input fifo_empty, input fifo_data, output fifo_pop);
  modport slave (output fifo_empty, output fifo_data, input fifo_pop);
endinterface

// File: rtl/osr.sv
// osr: PIO output shift register loaded by PULL/autopull/MOV and drained by OUT.
//  clk, reset (async, active-high), penable (SM clock enable)
//  set/din: direct load; do_pull/block/pull_default: PULL; do_out/shift/shift_right: OUT
//  autopull/pull_thresh: refill control, only honoured when OSR_AUTOPULL_EN is defined
//  fifo (osr_if.master): TX FIFO empty/data/pop
//  out_data, stalled: combinational; shift_reg_q, shift_count: registered state
module osr #(
  parameter logic [5:0] RESET_COUNT = 6'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        penable,
  input  logic        set,
  input  logic [31:0] din,
  input  logic        do_pull,
  input  logic        block,
  input  logic [31:0] pull_default,
  input  logic        do_out,
  input  logic [4:0]  shift,
  input  logic        shift_right,
  input  logic        autopull,
  input  logic [4:0]  pull_thresh,
  osr_if.master       fifo,
  output logic [31:0] out_data,
  output logic        stalled,
  output logic [31:0] shift_reg_q,
  output logic [5:0]  shift_count
);
  logic [31:0] shift_reg, out_bits;
  logic [5:0]  count, n;
  logic [6:0]  sum;
  logic        refill_due, sel_pull, sel_out, load_fifo, load_default, out_ok;
  assign n = shift == 5'd0 ? 6'd32 : {1'b0, shift};
`ifdef OSR_AUTOPULL_EN
  logic [5:0] thr;
  assign thr = pull_thresh == 5'd0 ? 6'd32 : {1'b0, pull_thresh};
  assign refill_due = autopull && count >= thr;
`else
  assign refill_due = 1'b0 & (autopull | (|pull_thresh));
`endif
  // Gating with !reset makes stall/pop drop the instant reset asserts.
  assign sel_pull = penable && !reset && !set && do_pull;
  assign sel_out = penable && !reset && !set && !do_pull && do_out;
  assign load_fifo = (sel_pull || (sel_out && refill_due)) && !fifo.fifo_empty;
  assign load_default = sel_pull && fifo.fifo_empty && !block;
  assign out_ok = sel_out && !refill_due;
  assign fifo.fifo_pop = load_fifo;
  assign stalled = (sel_pull && fifo.fifo_empty && block) || (sel_out && refill_due);
  // Shift amounts of 32 fall off the register, giving all-ones mask / zero result.
  assign out_bits = shift_right ? shift_reg & ~(32'hFFFF_FFFF << n) : shift_reg >> (6'd32 - n);
  assign out_data = out_ok ? out_bits : 32'd0;
  assign sum = {1'b0, count} + {1'b0, n};
  assign shift_reg_q = shift_reg;
  assign shift_count = count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shift_reg <= 32'd0;
      count <= RESET_COUNT;
    end else if (penable && set) begin
      shift_reg <= din;
      count <= 6'd0;
    end else if (load_fifo) begin
      shift_reg <= fifo.fifo_data;
      count <= 6'd0;
    end else if (load_default) begin
      shift_reg <= pull_default;
      count <= 6'd0;
    end else if (out_ok) begin
      shift_reg <= shift_right ? shift_reg >> n : shift_reg << n;
      count <= sum > 7'd32 ? 6'd32 : sum[5:0];
    end
endmodule

// File: tb/tb_osr.sv
// tb_osr: directed spec scenarios plus randomized traffic checked against an arithmetic OSR model.
module tb_osr;
`ifdef OSR_AUTOPULL_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif
  logic        clk = 1'b0, reset, penable, set, do_pull, block, do_out, shift_right, autopull;
  logic [31:0] din, pull_default, out_data, shift_reg_q;
  logic [4:0]  shift, pull_thresh;
  logic        stalled;
  logic [5:0]  shift_count;
  int n_assert = 0, n_fail = 0;
  longint unsigned m_reg;
  int m_cnt;
  osr_if fif();
  osr dut (
    .clk(clk), .reset(reset), .penable(penable), .set(set), .din(din),
    .do_pull(do_pull), .block(block), .pull_default(pull_default),
    .do_out(do_out), .shift(shift), .shift_right(shift_right),
    .autopull(autopull), .pull_thresh(pull_thresh), .fifo(fif.master),
    .out_data(out_data), .stalled(stalled), .shift_reg_q(shift_reg_q),
    .shift_count(shift_count)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    penable = 1'b1; set = 1'b0; do_pull = 1'b0; do_out = 1'b0; block = 1'b0;
    shift_right = 1'b1; autopull = 1'b0; shift = 5'd0; pull_thresh = 5'd0;
    din = 32'd0; pull_default = 32'd0; fif.fifo_empty = 1'b1; fif.fifo_data = 32'd0;
  endtask

  // Called just after a falling edge with inputs applied; checks the combinational
  // outputs, clocks once, then checks the registered state against the model.
  task automatic step(input string tag);
    int n, thr, ncnt;
    longint unsigned p2, nreg, e_out;
    bit e_pop, e_st;
    n = shift == 0 ? 32 : int'(shift);
    thr = pull_thresh == 0 ? 32 : int'(pull_thresh);
    p2 = 64'd1 << n;
    nreg = m_reg; ncnt = m_cnt; e_out = 0; e_pop = 0; e_st = 0;
    if (penable) begin
      if (set) begin
        nreg = din; ncnt = 0;
      end else if (do_pull) begin
        if (!fif.fifo_empty) begin nreg = fif.fifo_data; ncnt = 0; e_pop = 1; end
        else if (block) e_st = 1;
        else begin nreg = pull_default; ncnt = 0; end
      end else if (do_out) begin
        if (AP && autopull && m_cnt >= thr) begin
          e_st = 1;
          if (!fif.fifo_empty) begin e_pop = 1; nreg = fif.fifo_data; ncnt = 0; end
        end else begin
          if (shift_right) begin
            e_out = m_reg % p2; nreg = m_reg / p2;
          end else begin
            e_out = m_reg / (64'd1 << (32 - n)); nreg = (m_reg * p2) % (64'd1 << 32);
          end
          ncnt = m_cnt + n > 32 ? 32 : m_cnt + n;
        end
      end
    end
    #1;
    chk({tag, ".pop"}, {31'd0, fif.fifo_pop}, {31'd0, e_pop});
    chk({tag, ".stalled"}, {31'd0, stalled}, {31'd0, e_st});
    chk({tag, ".out_data"}, out_data, e_out[31:0]);
    @(posedge clk); #1;
    m_reg = nreg; m_cnt = ncnt;
    chk({tag, ".reg"}, shift_reg_q, m_reg[31:0]);
    chk({tag, ".count"}, {26'd0, shift_count}, m_cnt);
    @(negedge clk);
  endtask

  initial begin
    idle(); reset = 1'b1;
    m_reg = 0; m_cnt = 32;
    #1;
    chk("rst.reg", shift_reg_q, 32'd0);
    chk("rst.count", {26'd0, shift_count}, 32);
    chk("rst.pop", {31'd0, fif.fifo_pop}, 32'd0);
    chk("rst.stalled", {31'd0, stalled}, 32'd0);
    chk("rst.out", out_data, 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    // load, right shift, saturate
    set = 1'b1; din = 32'hA5A5_0F0F; step("t1");
    chk("t1.reg_spec", shift_reg_q, 32'hA5A50F0F);
    idle(); do_out = 1'b1; shift = 5'd8; shift_right = 1'b1;
    #1 chk("t2.out_spec", out_data, 32'h0F);
    step("t2");
    chk("t2.reg_spec", shift_reg_q, 32'h00A5A50F);
    chk("t2.count_spec", {26'd0, shift_count}, 8);
    shift = 5'd0;
    for (int i = 0; i < 4; i++) step("t2sat");
    chk("t2.sat", {26'd0, shift_count}, 32);
    // left shift
    idle(); set = 1'b1; din = 32'hF000_0001; step("t3load");
    idle(); do_out = 1'b1; shift = 5'd4; shift_right = 1'b0;
    #1 chk("t3.out_spec", out_data, 32'hF);
    step("t3");
    chk("t3.reg_spec", shift_reg_q, 32'h0000_0010);
    // blocking pull, then a push
    idle(); do_pull = 1'b1; block = 1'b1;
    for (int i = 0; i < 3; i++) step("t4block");
    fif.fifo_empty = 1'b0; fif.fifo_data = 32'h1234_5678; step("t4pull");
    chk("t4.reg_spec", shift_reg_q, 32'h12345678);
    idle(); do_pull = 1'b1; block = 1'b0; pull_default = 32'h0000_DEAD; step("t4nb");
    chk("t4nb.reg_spec", shift_reg_q, 32'h0000DEAD);
    // penable low: nothing happens even with data available
    idle(); penable = 1'b0; do_pull = 1'b1; fif.fifo_empty = 1'b0; fif.fifo_data = 32'h5555_AAAA;
    step("pen0");
    // autopull refill and retry
    idle(); set = 1'b1; din = 32'h0102_0304; step("t5load");
    idle(); do_out = 1'b1; shift = 5'd8; autopull = 1'b1; pull_thresh = 5'd8;
    step("t5pre");
    fif.fifo_empty = 1'b1; step("t5empty");
    fif.fifo_empty = 1'b0; fif.fifo_data = 32'hCAFE_BABE; step("t5refill");
    fif.fifo_empty = 1'b1; step("t5retry");
`ifdef OSR_AUTOPULL_EN
    chk("t5.reg_spec", shift_reg_q, 32'h00CAFEBA);
    chk("t5.count_spec", {26'd0, shift_count}, 8);
`endif
    // priority
    idle(); set = 1'b1; din = 32'h7777_0000; do_pull = 1'b1; do_out = 1'b1;
    fif.fifo_empty = 1'b0; fif.fifo_data = 32'h1111_1111; step("t6prio");
    chk("t6.reg_spec", shift_reg_q, 32'h77770000);
    // reset in the middle of a blocked pull
    idle(); do_pull = 1'b1; block = 1'b1;
    #1 chk("t6.pre_stall", {31'd0, stalled}, 32'd1);
    #1 reset = 1'b1; #1;
    chk("t6.rst_stall", {31'd0, stalled}, 32'd0);
    chk("t6.rst_pop", {31'd0, fif.fifo_pop}, 32'd0);
    chk("t6.rst_reg", shift_reg_q, 32'd0);
    chk("t6.rst_count", {26'd0, shift_count}, 32);
    m_reg = 0; m_cnt = 32;
    @(negedge clk); reset = 1'b0; idle();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      penable = $urandom_range(0, 7) != 0;
      set = $urandom_range(0, 9) == 0;
      do_pull = $urandom_range(0, 5) == 0;
      do_out = $urandom_range(0, 3) != 0;
      block = 1'($urandom);
      shift = 5'($urandom);
      shift_right = 1'($urandom);
      autopull = 1'($urandom);
      pull_thresh = 5'($urandom);
      din = $urandom;
      pull_default = $urandom;
      fif.fifo_empty = $urandom_range(0, 2) == 0;
      fif.fifo_data = $urandom;
      step("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
